// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clken_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gf180mcu_fd_sc_mcu7t5v0__clken_seq_if : request/enable bundle for seq    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface gf180mcu_fd_sc_mcu7t5v0__clken_seq_if #(
  parameter int N_BR = 4
);
  localparam int IW = $clog2(N_BR);

  logic [N_BR-1:0] REQ;
  logic [N_BR-1:0] EN;
  logic            CHG;
  logic [IW-1:0]   CHG_IDX;
  logic            BUSY;

  modport master (output REQ, input EN, input CHG, input CHG_IDX, input BUSY);
  modport slave  (input REQ, output EN, output CHG, output CHG_IDX, output BUSY);
endinterface
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clken_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gf180mcu_fd_sc_mcu7t5v0__clken_seq : staggered clock-branch enables,     |
// | round-robin, one toggle per STEP cycles. Option: GF180MCU_CLKSEQ_FAST_OFF_EN |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gf180mcu_fd_sc_mcu7t5v0__clken_seq #(
  parameter int N_BR = 4,
  parameter int STEP = 4
) (
  input  wire logic CLK,
  input  wire logic RST,
  inout  wire       VDD,
  inout  wire       VSS,
  gf180mcu_fd_sc_mcu7t5v0__clken_seq_if.slave seq
);
  localparam int CW = $clog2(STEP + 1);
  localparam int IW = $clog2(N_BR);
  localparam logic [CW-1:0] C_CNT_LOAD = CW'(STEP - 1);
  localparam logic [IW-1:0] C_LAST     = IW'(N_BR - 1);
  localparam logic [IW:0]   C_NBR      = (IW+1)'(N_BR);

  typedef enum logic [0:0] {
    S_READY  = 1'b0,
    S_SETTLE = 1'b1
  } state_t;

  logic [N_BR-1:0] r_en, w_en_nxt;
  logic            r_chg, w_chg_nxt;
  logic [IW-1:0]   r_chg_idx, w_chg_idx_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [N_BR-1:0] w_pending;
  logic [N_BR-1:0] w_sched;
  logic [IW-1:0]   w_sel;
  logic [IW:0]     w_sum;
  logic            w_found;
  state_t          w_state;

  wire w_unused_pwr = &{1'b0, VDD, VSS};

  assign w_pending = seq.REQ ^ r_en;
`ifdef GF180MCU_CLKSEQ_FAST_OFF_EN
  logic [N_BR-1:0] w_fast_off;
  assign w_fast_off = r_en & ~seq.REQ;
  assign w_sched    = seq.REQ & ~r_en;
`else
  assign w_sched    = w_pending;
`endif

  assign w_state = (r_cnt == '0) ? S_READY : S_SETTLE;

  // Round-robin search: first scheduled bit at or after r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int i = 0; i < N_BR; i++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_sum >= C_NBR) w_sum = w_sum - C_NBR;
      if (!w_found && w_sched[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    w_en_nxt      = r_en;
    w_chg_nxt     = 1'b0;
    w_chg_idx_nxt = r_chg_idx;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    case (w_state)
      S_READY: begin
        if (w_found) begin
          w_en_nxt[w_sel] = ~r_en[w_sel];
          w_chg_nxt       = 1'b1;
          w_chg_idx_nxt   = w_sel;
          w_ptr_nxt       = (w_sel == C_LAST) ? '0 : w_sel + 1'b1;
          w_cnt_nxt       = C_CNT_LOAD;
        end
      end
      S_SETTLE: w_cnt_nxt = r_cnt - 1'b1;
      default: ;
    endcase
`ifdef GF180MCU_CLKSEQ_FAST_OFF_EN
    // Disables bypass the spacing window; only turn-ons are scheduled.
    w_en_nxt = w_en_nxt & ~w_fast_off;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_en      <= '0;
      r_chg     <= 1'b0;
      r_chg_idx <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
    end else begin
      r_en      <= w_en_nxt;
      r_chg     <= w_chg_nxt;
      r_chg_idx <= w_chg_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign seq.EN      = r_en;
  assign seq.CHG     = r_chg;
  assign seq.CHG_IDX = r_chg_idx;
  assign seq.BUSY    = (|w_pending) | (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clken_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gf180mcu_fd_sc_mcu7t5v0__clken_seq : directed checks, STEP=4 and 1    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_gf180mcu_fd_sc_mcu7t5v0__clken_seq;
  logic CLK;
  logic RST;
  wire  vdd;
  wire  vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  gf180mcu_fd_sc_mcu7t5v0__clken_seq_if #(.N_BR(4)) seq0 ();
  gf180mcu_fd_sc_mcu7t5v0__clken_seq_if #(.N_BR(4)) seq1 ();

  gf180mcu_fd_sc_mcu7t5v0__clken_seq #(.N_BR(4), .STEP(4)) dut0 (
    .CLK(CLK), .RST(RST), .VDD(vdd), .VSS(vss), .seq(seq0.slave)
  );
  gf180mcu_fd_sc_mcu7t5v0__clken_seq #(.N_BR(4), .STEP(1)) dut1 (
    .CLK(CLK), .RST(RST), .VDD(vdd), .VSS(vss), .seq(seq1.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle0(input int max_edges);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (seq0.BUSY && k < max_edges);
    check("idle_bound", 32'(seq0.BUSY), 32'd0);
  endtask

  logic [3:0] clr_tab [4];

  initial begin
    int n;
    logic exp_chg;
    clr_tab[0] = 4'b1011;
    clr_tab[1] = 4'b0011;
    clr_tab[2] = 4'b0010;
    clr_tab[3] = 4'b0000;

    RST = 1'b1;
    seq0.REQ = 4'b0000;
    seq1.REQ = 4'b0000;
    #2;
    check("rst_en",   32'(seq0.EN), 32'd0);
    check("rst_chg",  32'(seq0.CHG), 32'd0);
    check("rst_idx",  32'(seq0.CHG_IDX), 32'd0);
    check("rst_busy", 32'(seq0.BUSY), 32'd0);
    check("rst_en1",  32'(seq1.EN), 32'd0);
    tick();
    tick();
    RST = 1'b0;

    // Test 1: all four branches requested, one toggle every 4 edges
    seq0.REQ = 4'b1111;
    for (int e = 1; e <= 16; e++) begin
      tick();
      n = (e - 1) / 4 + 1;
      if (n > 4) n = 4;
      exp_chg = ((e - 1) % 4 == 0) && (e <= 13);
      check("t1_en", 32'(seq0.EN), 32'((1 << n) - 1));
      check("t1_chg", 32'(seq0.CHG), 32'(exp_chg));
      if (exp_chg) check("t1_idx", 32'(seq0.CHG_IDX), 32'((e - 1) / 4));
      check("t1_busy", 32'(seq0.BUSY), 32'(e < 16));
    end

    // Test 2: bring ptr to 2 with EN=0000, then REQ=1001
    RST = 1'b1;
    seq0.REQ = 4'b0000;
    #1;
    RST = 1'b0;
    seq0.REQ = 4'b0010;
    tick();
    check("t2_on1", 32'(seq0.EN), 32'b0010);
    wait_idle0(8);
    seq0.REQ = 4'b0000;
    tick();
    check("t2_off1", 32'(seq0.EN), 32'b0000);
`ifdef GF180MCU_CLKSEQ_FAST_OFF_EN
    check("t2_off1_chg", 32'(seq0.CHG), 32'd0);
`else
    check("t2_off1_chg", 32'(seq0.CHG), 32'd1);
`endif
    wait_idle0(8);
    check("t2_ptr2", 32'(dut0.r_ptr), 32'd2);
    seq0.REQ = 4'b1001;
    tick();
    check("t2_en_a", 32'(seq0.EN), 32'b1000);
    check("t2_idx_a", 32'(seq0.CHG_IDX), 32'd3);
    check("t2_chg_a", 32'(seq0.CHG), 32'd1);
    for (int e = 0; e < 3; e++) begin
      tick();
      check("t2_gap_chg", 32'(seq0.CHG), 32'd0);
      check("t2_gap_en", 32'(seq0.EN), 32'b1000);
    end
    tick();
    check("t2_en_b", 32'(seq0.EN), 32'b1001);
    check("t2_idx_b", 32'(seq0.CHG_IDX), 32'd0);
    check("t2_chg_b", 32'(seq0.CHG), 32'd1);
    check("t2_ptr1", 32'(dut0.r_ptr), 32'd1);

    // Test 3: REQ[2] raised and withdrawn inside the spacing window
    seq0.REQ = 4'b1101;
    tick();
    check("t3_en1", 32'(seq0.EN), 32'b1001);
    check("t3_chg1", 32'(seq0.CHG), 32'd0);
    check("t3_busy1", 32'(seq0.BUSY), 32'd1);
    seq0.REQ = 4'b1001;
    tick();
    check("t3_busy2", 32'(seq0.BUSY), 32'd1);
    tick();
    check("t3_busy3", 32'(seq0.BUSY), 32'd0);
    for (int e = 0; e < 2; e++) begin
      tick();
      check("t3_en", 32'(seq0.EN), 32'b1001);
      check("t3_chg", 32'(seq0.CHG), 32'd0);
    end

    // Test 4: async reset between edges, then restart from ptr 0
    seq0.REQ = 4'b1111;
    tick();
    check("t4_en_pre", 32'(seq0.EN), 32'b1011);
    check("t4_idx_pre", 32'(seq0.CHG_IDX), 32'd1);
    #2;
    seq0.REQ = 4'b0000;
    RST = 1'b1;
    #1;
    check("t4_rst_en", 32'(seq0.EN), 32'd0);
    check("t4_rst_chg", 32'(seq0.CHG), 32'd0);
    check("t4_rst_busy", 32'(seq0.BUSY), 32'd0);
    #1;
    RST = 1'b0;
    seq0.REQ = 4'b0101;
    tick();
    check("t4_en_a", 32'(seq0.EN), 32'b0001);
    check("t4_idx_a", 32'(seq0.CHG_IDX), 32'd0);
    repeat (3) tick();
    tick();
    check("t4_en_b", 32'(seq0.EN), 32'b0101);
    check("t4_idx_b", 32'(seq0.CHG_IDX), 32'd2);

    // Test 5: all on, then all requests dropped (ptr is 2 at this point)
    seq0.REQ = 4'b1111;
    wait_idle0(16);
    check("t5_full", 32'(seq0.EN), 32'b1111);
    seq0.REQ = 4'b0000;
`ifdef GF180MCU_CLKSEQ_FAST_OFF_EN
    for (int e = 1; e <= 4; e++) begin
      tick();
      check("t5f_en", 32'(seq0.EN), 32'd0);
      check("t5f_chg", 32'(seq0.CHG), 32'd0);
      check("t5f_busy", 32'(seq0.BUSY), 32'd0);
    end
`else
    for (int e = 1; e <= 16; e++) begin
      tick();
      n = (e - 1) / 4;
      if (n > 3) n = 3;
      exp_chg = ((e - 1) % 4 == 0) && (e <= 13);
      check("t5_en", 32'(seq0.EN), 32'(clr_tab[n]));
      check("t5_chg", 32'(seq0.CHG), 32'(exp_chg));
      if (exp_chg) check("t5_idx", 32'(seq0.CHG_IDX), 32'((n + 2) % 4));
    end
`endif

    // Test 6: STEP=1 instance, one toggle per edge
    seq1.REQ = 4'b0011;
    tick();
    check("t6_en1", 32'(seq1.EN), 32'b0001);
    check("t6_idx1", 32'(seq1.CHG_IDX), 32'd0);
    check("t6_busy1", 32'(seq1.BUSY), 32'd1);
    tick();
    check("t6_en2", 32'(seq1.EN), 32'b0011);
    check("t6_idx2", 32'(seq1.CHG_IDX), 32'd1);
    check("t6_chg2", 32'(seq1.CHG), 32'd1);
    check("t6_busy2", 32'(seq1.BUSY), 32'd0);
    tick();
    check("t6_chg3", 32'(seq1.CHG), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
